// File: rtl/uart_frame_parser.sv
// Assembles SYNC/CMD/LEN/payload/CHK frames from an edge-qualified UART byte stream.
// Good frames are published with a one-cycle strobe; bad or stalled frames give an error strobe.
module uart_frame_parser #(
   parameter int          MAX_LEN        = 16,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 1000000,
   localparam int         LW             = $clog2(MAX_LEN + 1),
   localparam int         TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic [7:0]             cmd_out,
   output logic [LW-1:0]          len_out,
   output logic [8*MAX_LEN-1:0]   payload_out,
   output logic                   frame_valid,
   output logic                   frame_err,
   output logic [1:0]             err_code,
   output logic                   busy
);

   typedef enum logic [2:0] {IDLE, CMD, LEN, PAY, CHK} state_t;

   state_t                     state;
   logic                       rx_valid_q;
   logic [7:0]                 cmd_q;
   logic [LW-1:0]              len_q;
   logic [LW-1:0]              idx;
   logic [7:0]                 sum;
   logic [TW-1:0]              tmo_cnt;
   logic [MAX_LEN-1:0][7:0]    pbuf;
   logic                       accept;

   // rx_valid is level-held for many cycles, so only its rising edge carries a byte
   assign accept = rx_valid & ~rx_valid_q;
   assign busy   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rx_valid_q  <= 1'b1;
         cmd_q       <= '0;
         len_q       <= '0;
         idx         <= '0;
         sum         <= '0;
         tmo_cnt     <= '0;
         pbuf        <= '0;
         cmd_out     <= '0;
         len_out     <= '0;
         payload_out <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         err_code    <= '0;
      end else begin
         rx_valid_q  <= rx_valid;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         if (accept) begin
            tmo_cnt <= '0;
            case (state)
               IDLE: if (rx_data == SYNC_BYTE) state <= CMD;
               CMD: begin
                  cmd_q <= rx_data;
                  sum   <= rx_data;
                  state <= LEN;
               end
               LEN: begin
                  if (rx_data > 8'(MAX_LEN)) begin
                     state     <= IDLE;
                     frame_err <= 1'b1;
                     err_code  <= 2'd2;
                  end else begin
                     len_q <= rx_data[LW-1:0];
                     sum   <= sum + rx_data;
                     idx   <= '0;
                     state <= (rx_data == 8'd0) ? CHK : PAY;
                  end
               end
               PAY: begin
                  for (int i = 0; i < MAX_LEN; i++)
                     if (idx == LW'(i)) pbuf[i] <= rx_data;
                  sum <= sum + rx_data;
                  idx <= idx + LW'(1);
                  if (idx + LW'(1) == len_q) state <= CHK;
               end
               CHK: begin
                  state <= IDLE;
                  if (rx_data == sum) begin
                     frame_valid <= 1'b1;
                     cmd_out     <= cmd_q;
                     len_out     <= len_q;
                     // work buffer may hold stale bytes from longer earlier frames
                     for (int i = 0; i < MAX_LEN; i++)
                        payload_out[8*i +: 8] <= (LW'(i) < len_q) ? pbuf[i] : 8'd0;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= 2'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
               state     <= IDLE;
               tmo_cnt   <= '0;
               frame_err <= 1'b1;
               err_code  <= 2'd3;
            end else begin
               tmo_cnt <= tmo_cnt + TW'(1);
            end
         end
      end
   end

endmodule
